// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and mux select constants for the UART word arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  localparam logic MUX_SEL_A = 1'b0;
  localparam logic MUX_SEL_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
  import uart_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = req_a | req_b;
    if (req_a && req_b) begin
      grant_id = (last_grant == MUX_SEL_A) ? MUX_SEL_B : MUX_SEL_A;
    end else begin
      grant_id = req_b ? MUX_SEL_B : MUX_SEL_A;
    end
  end

endmodule

// File: rtl/uart_word_arbiter.sv
// rtl/uart_word_arbiter.sv - shares one UART between two word requesters via an external registered word mux
module uart_word_arbiter
  import uart_arb_pkg::*;
#(
  parameter int LENGTH = BYTES_PER_WORD * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              mux_sel,
  output logic              mux_enable,
  input  logic [LENGTH-1:0] mux_q,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy
);

  localparam int BYTES = LENGTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  state_t            state, state_d;
  logic              last_grant, last_grant_d;
  logic [LENGTH-1:0] shift, shift_d;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_d;
  logic              mux_sel_d, mux_enable_d, tx_start_d, ack_a_d, ack_b_d;
  logic [7:0]        tx_data_d;
  logic              arb_req_a, arb_req_b, grant_valid, grant_id;

  // A request whose ack is on the wire this cycle is being withdrawn; never regrant it.
  assign arb_req_a = req_a & ~ack_a;
  assign arb_req_b = req_b & ~ack_b;

  rr_arb2 u_arb (
    .req_a       (arb_req_a),
    .req_b       (arb_req_b),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    shift_d      = shift;
    byte_cnt_d   = byte_cnt;
    mux_sel_d    = mux_sel;
    mux_enable_d = 1'b0;
    tx_data_d    = tx_data;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          mux_sel_d    = grant_id;
          mux_enable_d = 1'b1;
          state_d      = ST_SEL;
        end
      end
      ST_SEL:  state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d    = mux_q;
        byte_cnt_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_start) state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          shift_d = shift >> 8;
          if (byte_cnt == LAST_BYTE) begin
            state_d = ST_DONE;
          end else begin
            byte_cnt_d = byte_cnt + 1'b1;
            state_d    = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        ack_a_d      = (mux_sel == MUX_SEL_A);
        ack_b_d      = (mux_sel == MUX_SEL_B);
        last_grant_d = mux_sel;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered start: the UART is known idle when we enter or sit in SEND with busy low.
    tx_start_d = (state_d == ST_SEND) && !tx_busy;
    if (tx_start_d) tx_data_d = shift_d[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= MUX_SEL_B;
      shift      <= '0;
      byte_cnt   <= '0;
      mux_sel    <= MUX_SEL_A;
      mux_enable <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      shift      <= shift_d;
      byte_cnt   <= byte_cnt_d;
      mux_sel    <= mux_sel_d;
      mux_enable <= mux_enable_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      ack_a      <= ack_a_d;
      ack_b      <= ack_b_d;
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: doc/uart_word_arbiter.md
# uart_word_arbiter

- Shares one UART transmitter between two 32-bit word requesters (A, B).
- Round-robin arbitration between A and B.
- Drives the select and enable of the registered 2-input word mux (`Mux_2in_1out`) that sits in front of the transmitter.
- Captures the mux output and serializes the word LSB-byte-first through the UART byte handshake, then acknowledges the served requester.

## Interface
Parameters:
- LENGTH, 32: word width; multiple of 8. BYTES = LENGTH/8 is derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_a  in  1  requester A wants its word sent; held until ack_a.
- req_b  in  1  requester B, same rules.
- ack_a  out  1  one-cycle pulse: A's word fully transmitted.
- ack_b  out  1  one-cycle pulse: B's word fully transmitted.
- mux_sel  out  1  to word mux: 0 = A, 1 = B.
- mux_enable  out  1  to word mux: load enable.
- mux_q  in  LENGTH  registered word-mux output.
- tx_data  out  8  byte to UART transmitter.
- tx_start  out  1  one-cycle start pulse to UART.
- tx_busy  in  1  UART busy; rises the cycle after tx_start, falls when the byte is done.
- busy  out  1  high whenever state is not IDLE.

## Operation
- State machine: IDLE, SEL, LOAD, SEND, WAIT_HI, WAIT_LO, DONE.
- **IDLE**
  - If req_a or req_b: grant one requester. With both asserted, grant the one not recorded in last_grant.
  - Register mux_sel to the granted requester and set mux_enable = 1; go to SEL.
- **SEL**: mux_sel and mux_enable are valid. The mux latches Q on the closing edge. Drop mux_enable; go to LOAD.
- **LOAD**: capture mux_q into the shift register; byte_cnt = 0; go to SEND.
- **SEND**
  - If tx_busy = 0: tx_data = shift[7:0], tx_start = 1 for this cycle; go to WAIT_HI.
  - Otherwise stay in SEND.
- **WAIT_HI**: wait for tx_busy = 1, then go to WAIT_LO.
- **WAIT_LO**
  - Wait for tx_busy = 0.
  - Then shift right by 8 and increment byte_cnt.
  - If byte_cnt was BYTES-1, go to DONE; else go to SEND.
- **DONE**: pulse ack of the granted requester; last_grant = granted; go to IDLE.
- Requesters must deassert req on the edge where their ack is high. IDLE therefore never regrants the same request.
- req is ignored outside IDLE. A request arriving mid-transfer waits in IDLE for arbitration.
- Exactly one ack pulse per granted word; never both acks in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, last_grant = B (A wins the first tie), shift register 0, byte_cnt 0.
- All outputs are registered.
- req sampled high in IDLE at cycle 0:
  - SEL at cycle 1.
  - LOAD at cycle 2.
  - First tx_start at cycle 3, if tx_busy = 0.
- Per byte: 1 (SEND) + ≥1 (WAIT_HI) + ≥1 (WAIT_LO) + UART busy time.
- With an ideal 1-cycle busy, one word takes 3 + 3·BYTES + 1 cycles from request to ack.
- tx_data holds its value from the tx_start cycle until the next SEND.
- Reset mid-transfer:
  - Immediate return to IDLE; tx_start and ack drop asynchronously.
  - The partial word is discarded, no ack is issued, and last_grant is reset.
- Byte counter width: clog2(BYTES); no wrap past BYTES-1.

## Structure
- Shared package `uart_arb_pkg` holds:
  - state enum (7 states);
  - BYTES_PER_WORD = 4 for LENGTH = 32;
  - MUX_SEL_A = 0 and MUX_SEL_B = 1.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker. Inputs: req_a, req_b, last_grant. Outputs: grant_valid, grant_id. Instantiated once.
- The word mux remains external. This block does not register requester data itself.

## Test plan
- Single A request, mux data 0x00000001, UART busy 1 cycle per byte:
  - mux_sel = 0 in SEL;
  - tx_data sequence 0x01, 0x00, 0x00, 0x00;
  - exactly one ack_a, at cycle 16;
  - no ack_b.
- Both req_a and req_b high at reset release, A = 0x00000001, B = 0x00000002:
  - A served first, then B with tx_data 0x02, 0x00, 0x00, 0x00;
  - a subsequent simultaneous request grants A again, because last_grant = B.
- req_b held continuously, req_a reasserted immediately after each ack_a:
  - grants alternate B, A, B, A;
  - neither requester is starved across 4 words.
- tx_busy held high for 5 cycles before the first byte:
  - FSM waits in SEND;
  - tx_start is asserted only after tx_busy falls;
  - bytes are unchanged.
- rst asserted during WAIT_LO of byte 2 for word 0xDEADBEEF:
  - outputs 0 immediately and no ack;
  - after release, a new request restarts from byte 0xEF.
